// File: rtl/rx_frame_ctrl_if.sv
// Output byte stream between rx_frame_ctrl and the host.
//   m_valid : head entry present
//   m_data  : byte at the FIFO head
//   m_err   : parity-error flag stored with the head byte
//   m_ready : consumer accepts the head entry
// Handshake: a transfer happens on every rising clock edge where
// m_valid && m_ready are both 1. m_data/m_err are only meaningful while
// m_valid is 1, and the producer never withdraws a valid entry before it is taken.
interface rx_frame_ctrl_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_err;
    logic       m_ready;

    modport master (output m_valid, output m_data, output m_err, input m_ready);
    modport slave  (input m_valid, input m_data, input m_err, output m_ready);
endinterface

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: sits between the UART receiver and the host.
//  - applies host baud/parity configuration only while the RX line is idle
//  - captures each received byte + parity-error flag into a small FIFO
//  - presents FIFO entries on a valid/ready stream (m_if)
//  - keeps a sticky overrun flag and a saturating parity-error counter
// Ports:
//   clock, rst            system clock, asynchronous active-high reset
//   serialInput           raw RX line, watched for idle
//   rx_ready/data/error   receiver frame-complete level, byte, parity error
//   cfg_we/baud/ptype     configuration request pulse and values
//   baudRate, pType       applied configuration
//   cfg_busy              a request is waiting to be applied
//   m_if                  output stream (master side)
//   overrun, err_count    sticky byte-lost flag, saturating error count
//   clr                   synchronous clear of overrun and err_count
//   dbg_state_o           current configuration FSM state
module rx_frame_ctrl #(
    parameter int DEPTH     = 4,
    parameter int IDLE_CLKS = 64,
    parameter int ERR_W     = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               serialInput,
    input  logic               rx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_error,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_baud,
    input  logic               cfg_ptype,
    output logic [1:0]         baudRate,
    output logic               pType,
    output logic               cfg_busy,
    rx_frame_ctrl_if.master    m_if,
    output logic               overrun,
    output logic [ERR_W-1:0]   err_count,
    input  logic               clr,
    output logic [1:0]         dbg_state_o
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDLE_W = $clog2(IDLE_CLKS + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } cfg_state_t;

    // ---------------- capture + FIFO ----------------
    logic             rx_ready_q;
    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             capture, fifo_empty, fifo_full, push, pop, drop;

    assign capture    = rx_ready & ~rx_ready_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign pop        = ~fifo_empty & m_if.m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = capture & (~fifo_full | pop);
    assign drop       = capture & fifo_full & ~pop;

    assign m_if.m_valid = ~fifo_empty;
    assign m_if.m_data  = mem_q[rd_ptr_q][7:0];
    assign m_if.m_err   = mem_q[rd_ptr_q][8];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rx_ready_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rx_ready_q <= rx_ready;
            if (push) begin
                mem_q[wr_ptr_q] <= {rx_error, rx_data};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // ---------------- overrun + error counter ----------------
    logic             overrun_q;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else if (clr) begin
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (drop) overrun_q <= 1'b1;
            // Dropped bytes still count: the error happened on the line.
            if (capture && rx_error && err_cnt_q != {ERR_W{1'b1}})
                err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign overrun   = overrun_q;
    assign err_count = err_cnt_q;

    // ---------------- idle detector ----------------
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              line_idle;

    assign line_idle = (idle_cnt_q == IDLE_W'(IDLE_CLKS));

    always_ff @(posedge clock or posedge rst) begin
        if (rst)               idle_cnt_q <= '0;
        else if (!serialInput) idle_cnt_q <= '0;
        else if (!line_idle)   idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
    end

    // ---------------- configuration FSM ----------------
    cfg_state_t state_q, state_d;
    logic [2:0] shadow_q, shadow_d;   // {baud, ptype}
    logic [1:0] baud_q;
    logic       ptype_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
            baud_q   <= 2'b00;
            ptype_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            // APPLY copies the shadow as it stood before any write arriving this cycle.
            if (state_q == ST_APPLY) begin
                baud_q  <= shadow_q[2:1];
                ptype_q <= shadow_q[0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cfg_busy = 1'b1;
        if (cfg_we) shadow_d = {cfg_baud, cfg_ptype};
        case (state_q)
            ST_RUN: begin
                cfg_busy = 1'b0;
                if (cfg_we) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (line_idle) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = cfg_we ? ST_PEND : ST_RUN;
            end
            default: begin
                state_d  = ST_RUN;
                cfg_busy = 1'b0;
            end
        endcase
    end

    assign baudRate    = baud_q;
    assign pType       = ptype_q;
    assign dbg_state_o = state_q;
endmodule
